juniversal_shift_register: RTL and testbench

- Parameterised universal shift register; default width is 4 bits.
- Four modes, selected by a 2-bit mode input: hold, shift right, shift left, and parallel load.
- The serial input for both shift directions is taken from DATAIN bit 0.
- Used as a generic storage and serialisation element. The output is the register contents directly, with no output logic.

---
 rtl/juniversal_shift_register_pkg.sv | 19 +
 rtl/juniversal_shift_register_usr_bit_cell.sv | 35 +++
 rtl/juniversal_shift_register.sv | 34 +++
 tb/tb_juniversal_shift_register.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/juniversal_shift_register_pkg.sv
// Shared definitions for the universal shift register:
// mode encodings and the default register width.
package juniversal_shift_register_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_SHR  = 2'b01,
        M_SHL  = 2'b10,
        M_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/juniversal_shift_register_usr_bit_cell.sv
// One storage bit of the universal shift register:
// a flop fed by a 4:1 mux over hold / right / left / load sources.
module usr_bit_cell
    import juniversal_shift_register_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       right_in,
    input  logic       left_in,
    input  logic       load_in,
    output logic       q
);

    logic d;

    always_comb begin
        d = q;
        unique case (mode)
            MODE_HOLD: d = q;
            MODE_SHR:  d = right_in;
            MODE_SHL:  d = left_in;
            MODE_LOAD: d = load_in;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/juniversal_shift_register.sv
// Parameterised universal shift register: hold, shift right,
// shift left and parallel load; DATAIN[0] is the serial input.
module juniversal_shift_register
    import juniversal_shift_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] DATAOUT,
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] DATAIN
);

    logic [WIDTH-1:0] right_src;
    logic [WIDTH-1:0] left_src;

    // Neighbour taps, with the serial bit entering at the open end
    assign right_src = {DATAIN[0], DATAOUT[WIDTH-1:1]};
    assign left_src  = {DATAOUT[WIDTH-2:0], DATAIN[0]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell u_cell (
            .clock    (clock),
            .reset    (reset),
            .mode     (MODE),
            .right_in (right_src[i]),
            .left_in  (left_src[i]),
            .load_in  (DATAIN[i]),
            .q        (DATAOUT[i])
        );
    end

endmodule

// File: tb/tb_juniversal_shift_register.sv
// Directed test for juniversal_shift_register (WIDTH = 4).
// Expected values are hand-computed constants.
module tb_juniversal_shift_register;

    logic       clock;
    logic       reset;
    logic [1:0] mode;
    logic [3:0] datain;
    logic [3:0] dataout;

    int n_cmp;
    int n_bad;

    juniversal_shift_register #(.WIDTH(4)) dut (
        .DATAOUT (dataout),
        .clock   (clock),
        .reset   (reset),
        .MODE    (mode),
        .DATAIN  (datain)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [3:0] d);
        mode   = m;
        datain = d;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b0;
        drive(2'b11, 4'b1111);
        #2;
        check("reset_init", dataout, 4'b0000);
        tick();
        check("reset_edge_ignored", dataout, 4'b0000);
        reset = 1'b1;

        // 1. Reset mid-operation
        drive(2'b11, 4'b1010);
        tick();
        check("load_before_reset", dataout, 4'b1010);
        drive(2'b01, 4'b0001);
        #3;
        reset = 1'b0;
        #1;
        check("async_clear", dataout, 4'b0000);
        tick();
        check("hold_low_edge1", dataout, 4'b0000);
        tick();
        check("hold_low_edge2", dataout, 4'b0000);
        reset = 1'b1;

        // 2. Shift right saturating with ones
        drive(2'b01, 4'b0011);
        tick();
        check("shr_1", dataout, 4'b1000);
        tick();
        check("shr_2", dataout, 4'b1100);
        tick();
        check("shr_3", dataout, 4'b1110);
        tick();
        check("shr_4", dataout, 4'b1111);
        tick();
        check("shr_sat", dataout, 4'b1111);
        drive(2'b01, 4'b1110);
        tick();
        check("shr_zero_fill", dataout, 4'b0111);

        // 3. Shift left
        drive(2'b11, 4'b0000);
        tick();
        check("clear_load", dataout, 4'b0000);
        drive(2'b10, 4'b0111);
        tick();
        check("shl_1", dataout, 4'b0001);
        tick();
        check("shl_2", dataout, 4'b0011);
        drive(2'b10, 4'b0110);
        tick();
        check("shl_3", dataout, 4'b0110);

        // 4. Parallel load then hold
        drive(2'b11, 4'b0000);
        tick();
        drive(2'b11, 4'b1010);
        tick();
        check("load", dataout, 4'b1010);
        drive(2'b00, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", dataout, 4'b1010);
        end

        // 5. Upper DATAIN bits ignored in shift
        drive(2'b11, 4'b0000);
        tick();
        drive(2'b01, 4'b1110);
        tick();
        check("ign_shr_1", dataout, 4'b0000);
        tick();
        check("ign_shr_2", dataout, 4'b0000);
        drive(2'b10, 4'b1110);
        tick();
        check("ign_shl", dataout, 4'b0000);

        // 6. Mid-stream mode change
        drive(2'b11, 4'b1001);
        tick();
        check("mix_load", dataout, 4'b1001);
        drive(2'b01, 4'b1110);
        tick();
        check("mix_shr", dataout, 4'b0100);
        drive(2'b10, 4'b0001);
        tick();
        check("mix_shl", dataout, 4'b1001);

        // Inputs changed between edges have no effect
        drive(2'b00, 4'b0000);
        tick();
        #2;
        drive(2'b11, 4'b0110);
        #1;
        check("between_edges", dataout, 4'b1001);
        drive(2'b00, 4'b0110);
        tick();
        check("after_glitch", dataout, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
